// File: rtl/sparc_ram_loader.sv
// sparc_ram_loader: streams source bytes into RAM through the MFC handshake,
// optionally reads them back to compare checksums, and holds the CPU meanwhile.
module sparc_ram_loader #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16,
  parameter int VERIFY  = 1
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Base,
  input  logic [ADDR_W:0]   Len,
  input  logic              In_Valid,
  input  logic [DATA_W-1:0] In_Data,
  output logic              In_Ready,
  output logic              Mem_En,
  output logic              Mem_RW,
  output logic [1:0]        Mem_Type,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Data,
  input  logic [DATA_W-1:0] Mem_Q,
  input  logic              Mem_MFC,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic              CPU_Hold,
  output logic [DATA_W-1:0] Checksum,
  output logic [ADDR_W-1:0] Err_Addr
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]  REM_ONE  = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_VREAD,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   remain;
  logic [ADDR_W:0]   len_q;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] rdsum;
  logic [DATA_W-1:0] rd_total;
  logic [ADDR_W-1:0] err_addr;
  logic [CNT_W-1:0]  cnt;

  logic start_ok;
  logic take;
  logic access;
  logic last;
  logic tmo;

  assign start_ok = Start &&
    (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign take     = (state == S_FETCH) && In_Valid;
  assign access   = (state == S_WRITE) || (state == S_VREAD);
  assign last     = (remain == REM_ONE);
  assign tmo      = access && !Mem_MFC && (cnt == CNT_LAST);
  assign rd_total = rdsum + Mem_Q;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start)
          state_nx = (Len == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        if (In_Valid)
          state_nx = S_WRITE;
      end
      S_WRITE: begin
        if (Mem_MFC) begin
          if (!last)
            state_nx = S_FETCH;
          else if (VERIFY != 0)
            state_nx = S_VREAD;
          else
            state_nx = S_DONE;
        end else if (tmo) begin
          state_nx = S_ERR;
        end
      end
      S_VREAD: begin
        if (Mem_MFC) begin
          if (last)
            state_nx = (rd_total == sum) ? S_DONE : S_ERR;
        end else if (tmo) begin
          state_nx = S_ERR;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      addr     <= '0;
      base_q   <= '0;
      remain   <= '0;
      len_q    <= '0;
      wdata    <= '0;
      sum      <= '0;
      rdsum    <= '0;
      err_addr <= '0;
      cnt      <= '0;
    end else begin
      // per-access MFC wait counter; restarts whenever an access completes
      cnt <= '0;
      if (access && !Mem_MFC)
        cnt <= cnt + CNT_W'(1);
      if (start_ok) begin
        addr   <= Base;
        base_q <= Base;
        remain <= Len;
        len_q  <= Len;
        sum    <= '0;
        rdsum  <= '0;
      end
      if (take) begin
        wdata <= In_Data;
        sum   <= sum + In_Data;
      end
      if (access && Mem_MFC) begin
        addr   <= addr + ADDR_W'(1);
        remain <= remain - REM_ONE;
        if (state == S_WRITE && last && VERIFY != 0) begin
          addr   <= base_q;
          remain <= len_q;
        end
        if (state == S_VREAD) begin
          rdsum <= rd_total;
          if (last && rd_total != sum)
            err_addr <= addr;
        end
      end
      if (tmo)
        err_addr <= addr;
    end
  end

  assign In_Ready = (state == S_FETCH);
  assign Mem_En   = access;
  assign Mem_RW   = (state != S_WRITE);
  assign Mem_Type = 2'b00;
  assign Mem_Addr = addr;
  assign Mem_Data = wdata;
  assign Busy     = (state == S_FETCH) || access;
  assign Done     = (state == S_DONE);
  assign Err      = (state == S_ERR);
  assign CPU_Hold = (state != S_DONE);
  assign Checksum = sum;
  assign Err_Addr = err_addr;

endmodule

// File: tb/tb_sparc_ram_loader.sv
// tb_sparc_ram_loader: randomized loads against a byte-level RAM/source model
// and a plain-arithmetic reference for addresses, checksum and verify result.
module tb_sparc_ram_loader;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          Clk = 1'b0;
  logic          Clr = 1'b0;
  logic          Start = 1'b0;
  logic [AW-1:0] Base = '0;
  logic [AW:0]   Len = '0;
  logic          In_Valid = 1'b0;
  logic [DW-1:0] In_Data = '0;
  logic          In_Ready;
  logic          Mem_En;
  logic          Mem_RW;
  logic [1:0]    Mem_Type;
  logic [AW-1:0] Mem_Addr;
  logic [DW-1:0] Mem_Data;
  logic [DW-1:0] Mem_Q = '0;
  logic          Mem_MFC = 1'b0;
  logic          Busy;
  logic          Done;
  logic          Err;
  logic          CPU_Hold;
  logic [DW-1:0] Checksum;
  logic [AW-1:0] Err_Addr;

  sparc_ram_loader #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT(TO),
    .VERIFY(1)
  ) dut (
    .Clk(Clk),
    .Clr(Clr),
    .Start(Start),
    .Base(Base),
    .Len(Len),
    .In_Valid(In_Valid),
    .In_Data(In_Data),
    .In_Ready(In_Ready),
    .Mem_En(Mem_En),
    .Mem_RW(Mem_RW),
    .Mem_Type(Mem_Type),
    .Mem_Addr(Mem_Addr),
    .Mem_Data(Mem_Data),
    .Mem_Q(Mem_Q),
    .Mem_MFC(Mem_MFC),
    .Busy(Busy),
    .Done(Done),
    .Err(Err),
    .CPU_Hold(CPU_Hold),
    .Checksum(Checksum),
    .Err_Addr(Err_Addr)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]    ram [512];
  logic [7:0]    src_q[$];
  logic [7:0]    bytes_q[$];
  logic [AW-1:0] wr_a[$];
  logic [7:0]    wr_d[$];
  logic [AW-1:0] rd_a[$];

  int            mfc_lat = 0;
  int            acc_wait = 0;
  int            valid_pct = 100;
  bit            lat_rand = 1'b0;
  bit            bad_en = 1'b0;
  logic [AW-1:0] bad_addr = '0;

  // One cycle: at the falling edge, answer the RAM request and drive the
  // source for the coming rising edge.
  task automatic step();
    bit v;
    @(negedge Clk);
    if (Mem_En && Clr) begin
      if (acc_wait >= mfc_lat) begin
        Mem_MFC = 1'b1;
        if (Mem_RW) begin
          Mem_Q = (bad_en && Mem_Addr == bad_addr) ? 8'h00 : ram[Mem_Addr];
          rd_a.push_back(Mem_Addr);
        end else begin
          ram[Mem_Addr] = Mem_Data;
          wr_a.push_back(Mem_Addr);
          wr_d.push_back(Mem_Data);
        end
        acc_wait = 0;
        if (lat_rand) mfc_lat = $urandom_range(0, 3);
      end else begin
        Mem_MFC = 1'b0;
        Mem_Q = 8'($urandom);
        acc_wait++;
      end
    end else begin
      Mem_MFC = 1'b0;
      Mem_Q = 8'($urandom);
      acc_wait = 0;
    end
    v = (src_q.size() > 0) && ($urandom_range(0, 99) < valid_pct);
    In_Valid = v;
    In_Data = v ? src_q[0] : 8'($urandom);
    if (v && In_Ready && Clr) void'(src_q.pop_front());
  endtask

  task automatic run_load(input string name, input logic [AW-1:0] base,
                          input int len, input bit bad_i_en,
                          input logic [AW-1:0] bad_i, input int poke_at,
                          input int budget, output int cycles);
    logic [7:0]    esum;
    logic [7:0]    ersum;
    logic [AW-1:0] a;
    logic [AW-1:0] elast;
    bit            eerr;
    int            bi;
    src_q = bytes_q;
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
    bad_en = bad_i_en;
    bad_addr = bad_i;
    esum = 8'h00;
    ersum = 8'h00;
    for (int i = 0; i < len; i++) begin
      a = base + AW'(i);
      esum = esum + bytes_q[i];
      ersum = ersum + ((bad_i_en && a == bad_i) ? 8'h00 : bytes_q[i]);
    end
    eerr = (len != 0) && (ersum != esum);
    elast = base + AW'(len - 1);
    Start = 1'b1;
    Base = base;
    Len = (AW+1)'(len);
    step();
    Start = 1'b0;
    cycles = 1;
    while (!(Done || Err) && cycles < budget) begin
      Start = (cycles == poke_at);
      if (Start) begin
        Base = base ^ 9'h155;
        Len = 10'd7;
      end
      step();
      cycles++;
    end
    Start = 1'b0;
    checks++;
    if (!(Done || Err)) begin
      errors++;
      $display("FAIL %s no completion: Done=%b Err=%b after %0d cycles",
               name, Done, Err, cycles);
    end
    checks++;
    if ({Done, Err, CPU_Hold, Busy, Mem_En} !== {!eerr, eerr, eerr, 2'b00}) begin
      errors++;
      $display("FAIL %s status: Done/Err/Hold/Busy/En=%b%b%b%b%b expected %b%b%b00",
               name, Done, Err, CPU_Hold, Busy, Mem_En, !eerr, eerr, eerr);
    end
    checks++;
    if (Checksum !== esum) begin
      errors++;
      $display("FAIL %s checksum: got %h expected %h", name, Checksum, esum);
    end
    if (eerr) begin
      checks++;
      if (Err_Addr !== elast) begin
        errors++;
        $display("FAIL %s err_addr: got %h expected %h", name, Err_Addr, elast);
      end
    end
    bi = -1;
    for (int i = 0; i < len && i < wr_a.size(); i++)
      if (bi < 0 && (wr_a[i] !== base + AW'(i) || wr_d[i] !== bytes_q[i])) bi = i;
    checks++;
    if (wr_a.size() != len || bi >= 0) begin
      errors++;
      $display("FAIL %s write log: %0d writes (expected %0d), first bad idx %0d",
               name, wr_a.size(), len, bi);
    end
    bi = -1;
    for (int i = 0; i < len && i < rd_a.size(); i++)
      if (bi < 0 && rd_a[i] !== base + AW'(i)) bi = i;
    checks++;
    if (rd_a.size() != len || bi >= 0) begin
      errors++;
      $display("FAIL %s read log: %0d reads (expected %0d), first bad idx %0d",
               name, rd_a.size(), len, bi);
    end
    bad_en = 1'b0;
  endtask

  task automatic test_reset();
    Clr = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if ({In_Ready, Mem_En, Mem_RW, Busy, Done, Err, CPU_Hold} !== 7'b0010001) begin
      errors++;
      $display("FAIL reset flags: Rdy/En/RW/Busy/Done/Err/Hold=%b%b%b%b%b%b%b expected 0010001",
               In_Ready, Mem_En, Mem_RW, Busy, Done, Err, CPU_Hold);
    end
    checks++;
    if ({Mem_Addr, Mem_Data, Checksum, Err_Addr, Mem_Type} !== '0) begin
      errors++;
      $display("FAIL reset values: addr=%h data=%h sum=%h eaddr=%h type=%b expected zero",
               Mem_Addr, Mem_Data, Checksum, Err_Addr, Mem_Type);
    end
    Clr = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int cyc;
    valid_pct = 100;
    mfc_lat = 0;
    lat_rand = 1'b0;
    bytes_q = '{8'h81, 8'h00, 8'h3C, 8'hFF};
    run_load("basic", 9'h000, 4, 1'b0, 9'h000, 0, 200, cyc);
    checks++;
    if (cyc != 13) begin
      errors++;
      $display("FAIL basic latency: got %0d cycles expected 13", cyc);
    end
    checks++;
    if (Checksum !== 8'hBC || CPU_Hold !== 1'b0) begin
      errors++;
      $display("FAIL basic result: sum=%h hold=%b expected BC 0", Checksum, CPU_Hold);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    bytes_q.delete();
    repeat (4) bytes_q.push_back(8'($urandom));
    run_load("wrap", 9'h1FE, 4, 1'b0, 9'h000, 0, 200, cyc);
    checks++;
    if (wr_a.size() != 4 || wr_a[2] !== 9'h000 || wr_a[3] !== 9'h001) begin
      errors++;
      $display("FAIL wrap addresses: %0d writes, third/fourth not 000/001", wr_a.size());
    end
  endtask

  task automatic test_timeout();
    logic [AW-1:0] b;
    int k;
    int m;
    b = 9'($urandom);
    mfc_lat = 1000;
    bytes_q = '{8'h11, 8'h22, 8'h33};
    src_q = bytes_q;
    wr_a.delete();
    wr_d.delete();
    Start = 1'b1;
    Base = b;
    Len = 10'd3;
    step();
    Start = 1'b0;
    k = 0;
    while (!Mem_En && k < 10) begin
      step();
      k++;
    end
    m = 0;
    while (!Err && m < 40) begin
      step();
      m++;
    end
    checks++;
    if (m != TO) begin
      errors++;
      $display("FAIL timeout latency: Err after %0d cycles expected %0d", m, TO);
    end
    checks++;
    if ({Err, Done, CPU_Hold, Mem_En, Busy} !== 5'b10100 || Err_Addr !== b) begin
      errors++;
      $display("FAIL timeout state: Err/Done/Hold/En/Busy=%b%b%b%b%b eaddr=%h expected 10100 %h",
               Err, Done, CPU_Hold, Mem_En, Busy, Err_Addr, b);
    end
    checks++;
    if (wr_a.size() != 0) begin
      errors++;
      $display("FAIL timeout writes: got %0d expected 0", wr_a.size());
    end
    mfc_lat = 0;
    src_q.delete();
    step();
  endtask

  task automatic test_corrupt();
    int cyc;
    bytes_q = '{8'h81, 8'h00, 8'h3C, 8'hFF};
    run_load("corrupt", 9'h010, 4, 1'b1, 9'h012, 0, 200, cyc);
    checks++;
    if (Err !== 1'b1 || Err_Addr !== 9'h013 || Checksum !== 8'hBC) begin
      errors++;
      $display("FAIL corrupt result: err=%b eaddr=%h sum=%h expected 1 013 BC",
               Err, Err_Addr, Checksum);
    end
  endtask

  task automatic test_len0_busy();
    int cyc;
    bytes_q.delete();
    run_load("len0", 9'($urandom), 0, 1'b0, 9'h000, 0, 20, cyc);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL len0 latency: got %0d cycles expected 1", cyc);
    end
    repeat (6) bytes_q.push_back(8'($urandom));
    run_load("busy_start", 9'h0C0, 6, 1'b0, 9'h000, 3, 200, cyc);
  endtask

  task automatic test_reset_mid();
    int k;
    int cyc;
    mfc_lat = 1000;
    bytes_q = '{8'h5A, 8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    src_q = bytes_q;
    Start = 1'b1;
    Base = 9'h040;
    Len = 10'd8;
    step();
    Start = 1'b0;
    k = 0;
    while (!(Mem_En && !Mem_RW) && k < 20) begin
      step();
      k++;
    end
    checks++;
    if (!(Mem_En && !Mem_RW)) begin
      errors++;
      $display("FAIL reset_mid setup: no write access seen, en=%b rw=%b", Mem_En, Mem_RW);
    end
    Clr = 1'b0;
    #1;
    checks++;
    if ({In_Ready, Mem_En, Mem_RW, Busy, Done, Err, CPU_Hold} !== 7'b0010001 ||
        {Mem_Addr, Mem_Data, Checksum, Err_Addr} !== '0) begin
      errors++;
      $display("FAIL reset_mid outputs: flags=%b%b%b%b%b%b%b addr=%h data=%h sum=%h expected 0010001 zeros",
               In_Ready, Mem_En, Mem_RW, Busy, Done, Err, CPU_Hold,
               Mem_Addr, Mem_Data, Checksum);
    end
    src_q.delete();
    repeat (2) step();
    Clr = 1'b1;
    mfc_lat = 0;
    acc_wait = 0;
    bytes_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    run_load("after_reset", 9'h0A5, 5, 1'b0, 9'h000, 0, 200, cyc);
  endtask

  task automatic test_random();
    int cyc;
    int len;
    logic [AW-1:0] b;
    bit be;
    logic [AW-1:0] ba;
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(1, 40);
      b = 9'($urandom);
      be = ($urandom_range(0, 2) == 0);
      ba = b + AW'($urandom_range(0, len - 1));
      lat_rand = 1'b1;
      mfc_lat = $urandom_range(0, 3);
      valid_pct = 60;
      bytes_q.delete();
      for (int i = 0; i < len; i++) bytes_q.push_back(8'($urandom));
      run_load("random", b, len, be, ba, 0, 40 + len * 30, cyc);
    end
    lat_rand = 1'b0;
    mfc_lat = 0;
    valid_pct = 100;
    b = 9'($urandom);
    bytes_q.delete();
    for (int i = 0; i < 512; i++) bytes_q.push_back(8'($urandom));
    run_load("full_mem", b, 512, 1'b0, 9'h000, 0, 4000, cyc);
    checks++;
    if (Mem_Addr !== b) begin
      errors++;
      $display("FAIL full_mem end address: got %h expected %h", Mem_Addr, b);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 8'h00;
    test_reset();
    test_basic();
    test_wrap();
    test_timeout();
    test_corrupt();
    test_len0_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sparc_ram_loader.md
# sparc_ram_loader

Synthesizable successor to the simulation-only byte preload of the SPARC MPU RAM: streams bytes from a ready/valid source into RAM through the memory-function-complete (MFC) handshake, holding the CPU off until loading finishes. Parametrised in address/data width, MFC timeout and an optional read-back verify pass with checksum compare. Sits between the boot/debug byte source and the RAM port, muxed ahead of the datapath MAR/MDR path while `CPU_Hold` is high.

## Interface
- `ADDR_W`, 9, RAM byte-address width; addresses wrap mod 2^ADDR_W
- `DATA_W`, 8, byte width; also checksum width
- `TIMEOUT`, 16, max cycles waiting for `Mem_MFC` per access (≥2)
- `VERIFY`, 1, 1 = read-back verify pass after write pass; 0 = none
- `Clk`  in  1  single clock, rising edge
- `Clr`  in  1  asynchronous, active-low reset
- `Start`  in  1  begin load; sampled only in IDLE/DONE/ERR
- `Base`  in  ADDR_W  first RAM address, latched on Start
- `Len`  in  ADDR_W+1  byte count (0..2^ADDR_W), latched on Start
- `In_Valid`  in  1  source byte valid
- `In_Data`  in  DATA_W  source byte
- `In_Ready`  out  1  loader accepts byte this cycle
- `Mem_En`  out  1  RAM access request (RAM `mov`)
- `Mem_RW`  out  1  0 = write, 1 = read (RAM `r_w`)
- `Mem_Type`  out  2  access size, constant 2'b00 (byte)
- `Mem_Addr`  out  ADDR_W  RAM address
- `Mem_Data`  out  DATA_W  write data
- `Mem_Q`  in  DATA_W  read data, valid when `Mem_MFC`=1 on a read
- `Mem_MFC`  in  1  memory function complete
- `Busy`, `Done`, `Err`  out  1 each  status
- `CPU_Hold`  out  1  keep MPU in reset/stall
- `Checksum`  out  DATA_W  sum mod 2^DATA_W of bytes written
- `Err_Addr`  out  ADDR_W  address associated with error

## Operation
- States: IDLE, FETCH, WRITE, VREAD, DONE, ERR. All outputs Moore (decoded from registered state/registers).
- IDLE/DONE/ERR + `Start`: latch Base→Addr, Len→Remain; clear Sum, RdSum, Done, Err. Len=0 → DONE; else → FETCH.
- FETCH: `In_Ready`=1. On `In_Valid`&&`In_Ready`: Mem_Data←In_Data, Sum←Sum+In_Data → WRITE.
- WRITE: `Mem_En`=1, `Mem_RW`=0. On `Mem_MFC`: Addr←Addr+1 (wraps), Remain−1; Remain was 1 → (VERIFY ? VREAD with Addr←Base, Remain←Len : DONE); else → FETCH.
- VREAD: `Mem_En`=1, `Mem_RW`=1. On `Mem_MFC`: RdSum←RdSum+Mem_Q, advance Addr/Remain; on last byte compare RdSum+Mem_Q with Sum: equal → DONE, else → ERR with Err_Addr = last address read.
- Timeout: cycle counter cleared on every entry to WRITE/VREAD; if `Mem_MFC` still low at count TIMEOUT−1 → ERR, Err_Addr = current Addr, no Addr advance.
- DONE: `Done`=1, `CPU_Hold`=0, `Checksum`=Sum. ERR: `Err`=1, `CPU_Hold`=1. `Busy`=1 in FETCH/WRITE/VREAD; `Start` ignored while Busy.
- `In_Ready` never asserted outside FETCH; source may hold `In_Valid` indefinitely.

## Timing
- Reset (Clr=0, immediate): state IDLE; In_Ready 0, Mem_En 0, Mem_RW 1, Mem_Addr 0, Mem_Data 0, Busy 0, Done 0, Err 0, CPU_Hold 1, Checksum 0, Err_Addr 0. Reset mid-access aborts with no further Mem_En.
- Start→first `In_Ready`: 1 cycle. Best case (In_Valid held, MFC same cycle as Mem_En): 2 cycles/byte write, 1 cycle/byte verify.
- `Mem_En` drops the cycle after `Mem_MFC` sampled high; Mem_Addr/Mem_Data stable throughout an access.
- Len=2^ADDR_W: full-memory load; addresses end back at Base.
- CPU_Hold falls in the same cycle Done rises.

## Test plan
- Reset, Start Base=0 Len=4, bytes 81,00,3C,FF, MFC immediate, faithful RAM model → writes 0..3, reads 0..3, Done=1, Checksum=BC, CPU_Hold=0, 13 cycles Start→Done.
- Base=1FE Len=4 → write addresses 1FE,1FF,000,001; Done, no Err.
- MFC never asserted, TIMEOUT=16 → ERR exactly 16 cycles after first Mem_En, Err_Addr=Base, CPU_Hold=1, Mem_En=0.
- RAM model corrupts byte at Base+2 (returns 00 for 3C), Base=10 Len=4 → ERR after verify, Err_Addr=013, Checksum=BC.
- Start with Len=0 → Done next cycle, Mem_En never asserted; Start pulsed while Busy → ignored.
- Clr low during WRITE with MFC pending → all outputs at reset values same cycle; new Start after release loads from new Base cleanly.
